traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
- Passive checker that observes the 6-bit lights bus and the carew sensor of the NS/EW traffic-light controller.
- Decodes lights into a phase number and flags illegal encodings and illegal phase sequences.
- Counts completed light cycles and error cycles.
- Used in simulation benches and as an on-chip safety monitor beside the controller; never drives the controller.

Parameters:
- CNT_W, 8, width of cycle_cnt and err_cnt; both saturate at 2^CNT_W-1.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous reset, active-low.
- lights  input  6  observed controller output; [5:3] = NS R/Y/G, [2:0] = EW R/Y/G.
- carew  input  1  observed EW car sensor, same signal the controller sees.
- err_clr  input  1  clears sticky error flags (sticky mode only; ignored otherwise).
- phase  output  2  decoded phase of last legal sample.
- phase_valid  output  1  last sample was a legal encoding.
- err_enc  output  1  illegal lights encoding detected.
- err_trans  output  1  illegal phase transition detected.
- cycle_cnt  output  CNT_W  completed full cycles, saturating.
- err_cnt  output  CNT_W  cycles with err_enc or err_trans set by the current sample, saturating.

Behaviour:
- Encoding table:
  - 6'b001100 = phase 0 (GNS_REW)
  - 6'b010100 = phase 1 (YNS_REW)
  - 6'b100001 = phase 2 (RNS_GEW)
  - 6'b100010 = phase 3 (RNS_YEW)
  - Any other value is illegal.
- Sampling: lights and carew are sampled on every posedge clk. All outputs are registered and reflect the sample from the same edge, so latency is 1 cycle from the lights change.
- Internal state:
  - prev_phase (2b) and prev_ok: last legal phase and its validity.
  - carew_q: carew at the previous edge.
  - first: set at reset, cleared on the first legal sample.
- Reset values: phase=0, phase_valid=0, err_enc=0, err_trans=0, cycle_cnt=0, err_cnt=0, prev_ok=0, carew_q=0, first=1.
- Illegal encoding:
  - Sets phase_valid=0 and err_enc=1; phase holds its previous value.
  - Clears prev_ok, so the next legal sample resynchronises with no transition check.
- Legal sample, first=1: must be phase 0, otherwise err_trans=1. first clears either way.
- Legal sample, prev_ok=1: check (p = prev_phase, n = new phase):
  - p=0, carew_q=0: n must be 0.
  - p=0, carew_q=1: n must be 1.
  - p=1: n must be 2.
  - p=2: n must be 3.
  - p=3: n must be 0.
  - Any other n sets err_trans=1. Holding phases 1, 2 or 3 for more than one sample is an error.
- Legal sample, prev_ok=0 and first=0: accepted, no error.
- Every legal sample loads prev_phase=n and sets prev_ok=1, including samples that raise err_trans (resync on the new phase).
- cycle_cnt: +1 on each checked legal 3->0 transition; holds at all-ones.
- err_cnt: +1 on any edge where err_enc or err_trans is raised by the current sample; holds at all-ones. Its behaviour is the same in sticky and non-sticky mode.
- Error flags (non-sticky mode): err_enc and err_trans are single-cycle pulses, recomputed every edge.
- Asserting rstn low mid-sequence returns all state to reset values immediately. The first legal post-reset sample must be phase 0.

Optional Feature:
- Macro: TLM_STICKY_ERR_EN.
- Defined:
  - err_enc and err_trans stay set once raised, until err_clr=1 is sampled.
  - If err_clr and a new error occur on the same edge, the flag ends set (new error wins).
  - err_cnt still counts per offending sample.
- Undefined: flags are single-cycle pulses and err_clr is ignored.

Test Plan:
- Reset, then drive 001100 -> 010100 -> 100001 -> 100010 -> 001100, with carew=1 on the edge before 010100:
  - phase follows 0,1,2,3,0.
  - No errors.
  - cycle_cnt=1 one cycle after the final 001100.
- Hold 001100 for 5 edges with carew=0 -> no errors. Then carew=1 for one edge while lights stay 001100 -> err_trans=1 on the next edge, err_cnt=1.
- Drive 000000 after phase 2 -> err_enc=1 and phase_valid=0. Then 001100 -> accepted with no err_trans, phase=0.
- Drive 001100 -> 100001 (skip phase 1) -> err_trans=1. Then 100010 -> no error (resynced on phase 2).
- With CNT_W=2, run 5 full cycles -> cycle_cnt saturates at 3. Assert rstn low mid-phase 2 -> all outputs 0. First post-reset sample 100001 -> err_trans=1.
- With TLM_STICKY_ERR_EN, one illegal sample 111111 -> err_enc stays 1 for 10 cycles. Pulse err_clr -> cleared on the next edge. Repeat with err_clr coincident with a new error -> err_enc stays 1.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive NS/EW traffic-light checker: decodes the lights bus into a phase, flags illegal
// encodings and phase sequences, and counts cycles/errors. Define TLM_STICKY_ERR_EN for sticky flags.
module traffic_light_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       lights,
  input  logic             carew,
  input  logic             err_clr,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic             err_enc,
  output logic             err_trans,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic [1:0] prev_phase;
  logic       prev_ok;
  logic       carew_q;
  logic       first;

  logic       legal;
  logic [1:0] new_phase;
  logic [1:0] next_exp;
  logic       new_enc;
  logic       new_trans;
  logic       wrap;

  always_comb begin
    legal     = 1'b1;
    new_phase = 2'd0;
    unique case (lights)
      6'b001100: new_phase = 2'd0;
      6'b010100: new_phase = 2'd1;
      6'b100001: new_phase = 2'd2;
      6'b100010: new_phase = 2'd3;
      default:   legal     = 1'b0;
    endcase

    // Phase 0 only advances when EW demand was seen on the previous edge.
    unique case (prev_phase)
      2'd0:    next_exp = carew_q ? 2'd1 : 2'd0;
      2'd1:    next_exp = 2'd2;
      2'd2:    next_exp = 2'd3;
      default: next_exp = 2'd0;
    endcase

    new_enc   = !legal;
    new_trans = legal && (first ? (new_phase != 2'd0)
                                : (prev_ok && (new_phase != next_exp)));
    wrap      = legal && !first && prev_ok && (prev_phase == 2'd3) && (new_phase == 2'd0);
  end

`ifndef TLM_STICKY_ERR_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase       <= 2'd0;
      phase_valid <= 1'b0;
      err_enc     <= 1'b0;
      err_trans   <= 1'b0;
      cycle_cnt   <= '0;
      err_cnt     <= '0;
      prev_phase  <= 2'd0;
      prev_ok     <= 1'b0;
      carew_q     <= 1'b0;
      first       <= 1'b1;
    end else begin
      carew_q <= carew;
      if (legal) begin
        phase       <= new_phase;
        phase_valid <= 1'b1;
        prev_phase  <= new_phase;
        prev_ok     <= 1'b1;
        first       <= 1'b0;
      end else begin
        phase_valid <= 1'b0;
        prev_ok     <= 1'b0;
      end

`ifdef TLM_STICKY_ERR_EN
      // A new error on the same edge as err_clr keeps the flag set.
      err_enc   <= new_enc   | (err_enc   & ~err_clr);
      err_trans <= new_trans | (err_trans & ~err_clr);
`else
      err_enc   <= new_enc;
      err_trans <= new_trans;
`endif

      if (wrap && (cycle_cnt != {CNT_W{1'b1}})) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if ((new_enc || new_trans) && (err_cnt != {CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
